// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger playfield.
// Holds the grid geometry, the start/goal rows, the frog FSM state
// encoding and a helper that maps a (row, col) cell onto its bit in the
// 64-bit hazard map.
package frogger_pkg;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;

  localparam logic [2:0] START_ROW    = 3'd0;
  localparam logic [2:0] GOAL_ROW     = 3'd7;
  // Last row before the goal; an up move from here completes a crossing.
  localparam logic [2:0] PRE_GOAL_ROW = 3'd6;
  localparam logic [2:0] MAX_COL      = 3'd7;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WIN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_WAIT = 2'd3
  } frog_state_t;

  // Hazard map bit for a cell: row*8 + col, i.e. the row and column
  // concatenated.
  function automatic logic [5:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/frog_controller.sv
// Frog movement / collision controller for one player.
// Moves the frog one cell per debounced pulse, detects collisions with the
// live hazard map, emits a one-cycle clear pulse on reaching the goal row
// and a one-cycle dead pulse on a collision, followed by a hidden respawn
// period. All outputs are registered.
//
// Ports:
//   clk          - clock, all state updates on rising edge
//   reset        - synchronous active-high reset
//   up/down/left/right - one-cycle move pulses (priority up>down>left>right)
//   gameOver     - freezes play while high (in PLAY only)
//   hazard[63:0] - hazard map, bit row*8+col
//   frogRow/frogCol - frog position
//   frogVisible  - frog drawn when high
//   clear        - one-cycle win pulse (to score stage)
//   dead         - one-cycle collision pulse
module frog_controller
  import frogger_pkg::*;
#(
  parameter int RESPAWN_CYCLES = 4,
  parameter int START_COL      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        gameOver,
  input  logic [63:0] hazard,
  output logic [2:0]  frogRow,
  output logic [2:0]  frogCol,
  output logic        frogVisible,
  output logic        clear,
  output logic        dead
);

  localparam logic [2:0] START_COL_L = 3'(START_COL);
  localparam logic [7:0] RESPAWN_L   = 8'(RESPAWN_CYCLES);

  frog_state_t state_r, state_n;
  logic [2:0]  row_r, row_n;
  logic [2:0]  col_r, col_n;
  logic [7:0]  cnt_r, cnt_n;
  logic        visible_r, clear_r, dead_r;
  logic        hit_s;

  // Start and goal rows are safe zones; only rows 1..6 can collide.
  assign hit_s = (row_r != START_ROW) && (row_r != GOAL_ROW) &&
                 hazard[cell_index(row_r, col_r)];

  // Next-state, next-position and respawn counter logic.
  always_comb begin
    state_n = state_r;
    row_n   = row_r;
    col_n   = col_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_PLAY: begin
        if (gameOver) begin
          state_n = ST_PLAY;
        end else if (hit_s) begin
          // The move arriving in the collision cycle is discarded.
          state_n = ST_HIT;
        end else if (up) begin
          if (row_r == PRE_GOAL_ROW) begin
            row_n   = GOAL_ROW;
            state_n = ST_WIN;
          end else if (row_r < PRE_GOAL_ROW) begin
            row_n = row_r + 3'd1;
          end else begin
            row_n = row_r;
          end
        end else if (down) begin
          if (row_r != START_ROW) begin
            row_n = row_r - 3'd1;
          end else begin
            row_n = row_r;
          end
        end else if (left) begin
          if (col_r != 3'd0) begin
            col_n = col_r - 3'd1;
          end else begin
            col_n = col_r;
          end
        end else if (right) begin
          if (col_r != MAX_COL) begin
            col_n = col_r + 3'd1;
          end else begin
            col_n = col_r;
          end
        end else begin
          state_n = ST_PLAY;
        end
      end
      ST_WIN: begin
        state_n = ST_PLAY;
        row_n   = START_ROW;
        col_n   = START_COL_L;
      end
      ST_HIT: begin
        state_n = ST_WAIT;
        cnt_n   = RESPAWN_L;
      end
      ST_WAIT: begin
        // Counter value 1 marks the final hidden cycle.
        if (cnt_r <= 8'd1) begin
          state_n = ST_PLAY;
          row_n   = START_ROW;
          col_n   = START_COL_L;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt_r - 8'd1;
        end
      end
      default: begin
        state_n = ST_PLAY;
        row_n   = START_ROW;
        col_n   = START_COL_L;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // State, position, counter and Moore output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_PLAY;
      row_r     <= START_ROW;
      col_r     <= START_COL_L;
      cnt_r     <= 8'd0;
      visible_r <= 1'b1;
      clear_r   <= 1'b0;
      dead_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      row_r     <= row_n;
      col_r     <= col_n;
      cnt_r     <= cnt_n;
      visible_r <= (state_n == ST_PLAY) || (state_n == ST_WIN);
      clear_r   <= (state_n == ST_WIN);
      dead_r    <= (state_n == ST_HIT);
    end
  end

  assign frogRow     = row_r;
  assign frogCol     = col_r;
  assign frogVisible = visible_r;
  assign clear       = clear_r;
  assign dead        = dead_r;

endmodule

// File: tb/tb_frog_controller.sv
// Self-checking bench for frog_controller: directed scenarios plus a
// randomized run against a behavioural model of the game rules.
module tb_frog_controller;

  localparam int RESP = 4;
  localparam int SCOL = 3;

  logic        clk = 1'b0;
  logic        reset, up, down, left, right, gameOver;
  logic [63:0] hazard;
  logic [2:0]  frogRow, frogCol;
  logic        frogVisible, clear, dead;

  int checks = 0;
  int errors = 0;

  // Model state: position, remaining hidden cycles, pending win/dead pulse.
  int m_row, m_col, m_hidden;
  bit m_win, m_dead;

  frog_controller #(.RESPAWN_CYCLES(RESP), .START_COL(SCOL)) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .gameOver(gameOver), .hazard(hazard), .frogRow(frogRow), .frogCol(frogCol),
    .frogVisible(frogVisible), .clear(clear), .dead(dead)
  );

  always #5 clk = ~clk;

  // Rules of the game, applied once per clock edge.
  task automatic model_step(input bit r, u, d, l, rt, go, input logic [63:0] hz);
    if (r) begin
      m_row = 0; m_col = SCOL; m_hidden = 0; m_win = 0; m_dead = 0;
    end else if (m_win) begin
      m_win = 0; m_row = 0; m_col = SCOL;
    end else if (m_hidden > 0) begin
      m_dead = 0;
      m_hidden--;
      if (m_hidden == 0) begin m_row = 0; m_col = SCOL; end
    end else if (go) begin
      m_dead = 0;
    end else if (m_row >= 1 && m_row <= 6 && hz[m_row*8 + m_col]) begin
      m_hidden = RESP + 1; m_dead = 1;
    end else begin
      m_dead = 0;
      if (u) begin
        m_row++;
        if (m_row == 7) m_win = 1;
      end else if (d) begin
        if (m_row > 0) m_row--;
      end else if (l) begin
        if (m_col > 0) m_col--;
      end else if (rt) begin
        if (m_col < 7) m_col++;
      end
    end
  endtask

  function automatic logic [8:0] model_vec();
    return {3'(m_row), 3'(m_col), (m_hidden == 0), m_win, m_dead};
  endfunction

  task automatic step(input bit r, u, d, l, rt, go, input logic [63:0] hz);
    reset = r; up = u; down = d; left = l; right = rt; gameOver = go; hazard = hz;
    @(posedge clk);
    model_step(r, u, d, l, rt, go, hz);
    #1;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 64'd0);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0, 64'd0);
    checks++;
    if ({frogRow, frogCol, frogVisible, clear, dead} !== {3'd0, 3'd3, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got row=%0d col=%0d vis=%b clr=%b dead=%b, want 0 3 1 0 0",
               frogRow, frogCol, frogVisible, clear, dead);
    end
  endtask

  task automatic test_climb_win;
    step(1, 0, 0, 0, 0, 0, 64'd0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0, 64'd0);
    checks++;
    if ({frogRow, frogCol, frogVisible, clear, dead} !== {3'd7, 3'd3, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL win_pulse: got row=%0d col=%0d vis=%b clr=%b dead=%b, want 7 3 1 1 0",
               frogRow, frogCol, frogVisible, clear, dead);
    end
    idle(1);
    checks++;
    if ({frogRow, frogCol, frogVisible, clear, dead} !== {3'd0, 3'd3, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL win_respawn: got row=%0d col=%0d vis=%b clr=%b dead=%b, want 0 3 1 0 0",
               frogRow, frogCol, frogVisible, clear, dead);
    end
  endtask

  task automatic test_collision;
    int hidden_cnt;
    int dead_cnt;
    step(1, 0, 0, 0, 0, 0, 64'd0);
    step(0, 1, 0, 0, 0, 0, 64'd0);
    step(0, 1, 0, 0, 0, 0, 64'd0);
    hidden_cnt = 0;
    dead_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 0, 0, 0, 64'd1 << 19);
      if (!frogVisible) hidden_cnt++;
      if (dead) dead_cnt++;
      if (i == 0) begin
        checks++;
        if (dead !== 1'b1 || frogVisible !== 1'b0) begin
          errors++;
          $display("FAIL hit_first_cycle: got dead=%b vis=%b, want 1 0", dead, frogVisible);
        end
      end
    end
    checks++;
    if (hidden_cnt != RESP + 1) begin
      errors++;
      $display("FAIL hidden_time: got %0d cycles, want %0d", hidden_cnt, RESP + 1);
    end
    checks++;
    if (dead_cnt != 1) begin
      errors++;
      $display("FAIL dead_pulse_len: got %0d cycles, want 1", dead_cnt);
    end
    checks++;
    if ({frogRow, frogCol, frogVisible} !== {3'd0, 3'd3, 1'b1}) begin
      errors++;
      $display("FAIL hit_respawn: got row=%0d col=%0d vis=%b, want 0 3 1", frogRow, frogCol, frogVisible);
    end
  endtask

  task automatic test_boundaries;
    step(1, 0, 0, 0, 0, 0, 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 64'd0);
    step(0, 0, 0, 1, 0, 0, 64'd0);
    step(0, 0, 1, 0, 0, 0, 64'd0);
    checks++;
    if ({frogRow, frogCol} !== {3'd0, 3'd0}) begin
      errors++;
      $display("FAIL edge_left_down: got row=%0d col=%0d, want 0 0", frogRow, frogCol);
    end
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0, 64'd0);
    step(0, 0, 0, 0, 1, 0, 64'd0);
    checks++;
    if ({frogRow, frogCol} !== {3'd0, 3'd7}) begin
      errors++;
      $display("FAIL edge_right: got row=%0d col=%0d, want 0 7", frogRow, frogCol);
    end
  endtask

  task automatic test_priority;
    step(1, 0, 0, 0, 0, 0, 64'd0);
    step(0, 1, 0, 0, 1, 0, 64'd0);
    checks++;
    if ({frogRow, frogCol} !== {3'd1, 3'd3}) begin
      errors++;
      $display("FAIL up_over_right: got row=%0d col=%0d, want 1 3", frogRow, frogCol);
    end
    // Cell (1,3) is bit 11: collision with a simultaneous up pulse.
    step(0, 1, 0, 0, 0, 0, 64'd1 << 11);
    checks++;
    if ({frogRow, frogCol, frogVisible, dead} !== {3'd1, 3'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL hit_beats_up: got row=%0d col=%0d vis=%b dead=%b, want 1 3 0 1",
               frogRow, frogCol, frogVisible, dead);
    end
    idle(RESP + 1);
  endtask

  task automatic test_game_over;
    step(1, 0, 0, 0, 0, 0, 64'd0);
    step(0, 1, 0, 0, 0, 0, 64'd0);
    step(0, 1, 0, 0, 0, 0, 64'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 64'd1 << 19);
    checks++;
    if ({frogRow, frogCol, frogVisible, clear, dead} !== {3'd2, 3'd3, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL game_over_hold: got row=%0d col=%0d vis=%b clr=%b dead=%b, want 2 3 1 0 0",
               frogRow, frogCol, frogVisible, clear, dead);
    end
  endtask

  task automatic test_reset_in_wait;
    step(1, 0, 0, 0, 0, 0, 64'd0);
    step(0, 1, 0, 0, 0, 0, 64'd0);
    step(0, 0, 0, 0, 0, 0, 64'd1 << 11);
    step(0, 0, 0, 0, 0, 0, 64'd0);
    step(0, 0, 0, 0, 0, 0, 64'd0);
    step(1, 0, 0, 0, 0, 0, 64'd0);
    checks++;
    if ({frogRow, frogCol, frogVisible, dead} !== {3'd0, 3'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_in_wait: got row=%0d col=%0d vis=%b dead=%b, want 0 3 1 0",
               frogRow, frogCol, frogVisible, dead);
    end
  endtask

  task automatic test_random;
    logic [63:0] hz;
    bit go, r;
    bit prev_clear, prev_dead;
    int bad;
    go = 0;
    prev_clear = 0;
    prev_dead = 0;
    step(1, 0, 0, 0, 0, 0, 64'd0);
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      hz = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      if ($urandom_range(0, 39) == 0) go = ~go;
      r = ($urandom_range(0, 199) == 0);
      step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, go, hz);
      checks++;
      if ({frogRow, frogCol, frogVisible, clear, dead} !== model_vec()) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cycle_%0d: got %b, want %b (row,col,vis,clr,dead)",
                   i, {frogRow, frogCol, frogVisible, clear, dead}, model_vec());
        bad++;
      end
      checks++;
      if ((clear && dead) || (clear && prev_clear) || (dead && prev_dead)) begin
        errors++;
        $display("FAIL pulse_rules_%0d: clr=%b dead=%b prev_clr=%b prev_dead=%b",
                 i, clear, dead, prev_clear, prev_dead);
      end
      prev_clear = clear;
      prev_dead = dead;
    end
  endtask

  initial begin
    reset = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    gameOver = 1'b0; hazard = 64'd0;
    m_row = 0; m_col = SCOL; m_hidden = 0; m_win = 0; m_dead = 0;
    @(negedge clk);
    test_reset();
    test_climb_win();
    test_collision();
    test_boundaries();
    test_priority();
    test_game_over();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frog_controller.md
FROG_CONTROLLER -- requirements
Module: frog_controller

Interface
REQ-001 Parameter: RESPAWN_CYCLES, 4, number of cycles the frog stays hidden after a collision (range 1..255).
REQ-002 Parameter: START_COL, 3, column where the frog spawns on row 0.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: up, down, left, right  input  1 each  one-cycle debounced move pulses.
REQ-006 Port: gameOver  input  1  high while the score stage reports 9 wins; freezes play.
REQ-007 Port: hazard  input  64  live hazard map; bit row*8+col set = hazard occupies that cell.
REQ-008 Port: frogRow  output  3  frog row; 0 = start row, 7 = goal row.
REQ-009 Port: frogCol  output  3  frog column; 0 = leftmost.
REQ-010 Port: frogVisible  output  1  frog is drawn when high.
REQ-011 Port: clear  output  1  one-cycle win pulse; this output drives the win input of the score stage.
REQ-012 Port: dead  output  1  one-cycle collision pulse.

Function
REQ-013 FSM states: PLAY, WIN, HIT, WAIT; all outputs are Moore, driven from registered state.
REQ-014 PLAY, gameOver=0, no collision: exactly one move is applied per cycle, with priority up > down > left > right.
REQ-015 Boundaries: down at row 0, left at col 0, and right at col 7 are ignored; the position is unchanged and no error is flagged.
REQ-016 PLAY: an up move from row 6 sets row to 7 and the next state to WIN; hazard bits on row 7 are ignored.
REQ-017 WIN: clear=1 for exactly one cycle with the frog shown at (7,col); the next state is PLAY at (0,START_COL).
REQ-018 Collision: in PLAY, with frogRow in 1..6 and hazard[frogRow*8+frogCol]=1, the next state is HIT; a move in the same cycle is discarded.
REQ-019 Rows 0 and 7 are safe zones; their hazard bits never cause a collision.
REQ-020 HIT: dead=1 and frogVisible=0 for one cycle; the respawn counter loads RESPAWN_CYCLES; the next state is WAIT.
REQ-021 WAIT: frogVisible=0; the counter decrements each cycle, and when it reaches 1 the next state is PLAY at (0,START_COL) with frogVisible=1.
REQ-022 The total hidden time (HIT + WAIT) is RESPAWN_CYCLES+1 cycles.
REQ-023 gameOver=1 in PLAY: moves and collisions are ignored, the position is held, and clear=0 and dead=0.
REQ-024 gameOver does not abort WIN, HIT or WAIT; these states complete, then the frog holds in PLAY.
REQ-025 clear and dead are never high in the same cycle; neither is ever high for two consecutive cycles.
REQ-026 Move pulses arriving in WIN, HIT or WAIT are dropped, not queued.

Reset
REQ-027 reset=1 on a clock edge forces: state PLAY, frogRow=0, frogCol=START_COL, frogVisible=1, clear=0, dead=0, counter=0.
REQ-028 Reset overrides every state, including mid-WAIT and mid-WIN; a pending clear or dead pulse is suppressed.

Structure
REQ-029 Shared package frogger_pkg holds: GRID_ROWS=8, GRID_COLS=8, START_ROW=0, GOAL_ROW=7, and the FSM state enum.
REQ-030 The respawn counter is inline; no sub-module is required. The block is instantiated once per player, ahead of that player's score stage.

Verification
REQ-031 Reset, then seven up pulses with hazard=0: the frog reaches (7,3); clear=1 for one cycle; the next cycle shows (0,3).
REQ-032 Frog at (2,3), hazard bit 19 set: dead=1 for one cycle; frogVisible=0 for 5 cycles (RESPAWN_CYCLES=4); then the frog appears at (0,3).
REQ-033 At (0,0), pulse left and down: the position stays (0,0). At (0,7), pulse right: the position stays (0,7).
REQ-034 up and right pulsed in the same cycle at (0,3): the result is (1,3). A collision and an up pulse in the same cycle: HIT is entered and the position is unchanged.
REQ-035 gameOver=1 with hazard under the frog and up pulses: no movement, and clear=0, dead=0.
REQ-036 Reset asserted during WAIT: the next cycle shows (0,3), frogVisible=1, and dead=0.
